// File: rtl/inst_decode_pkg.sv
// Shared opcode constants, instruction class enum and decoded-record type
// for the instruction decode stage.
package inst_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    IT_R = 2'd0,
    IT_I = 2'd1,
    IT_J = 2'd2
  } itype_t;

  typedef struct packed {
    itype_t      itype;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [25:0] address;
  } dec_t;

endpackage

// File: rtl/inst_field_decode.sv
// Combinational MIPS-32 field splitter: instruction word -> decoded record.
// Optional macro INST_DECODE_TARGET_EN adds a next-PC candidate output.
module inst_field_decode
  import inst_decode_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [31:0]     instruction,
`ifdef INST_DECODE_TARGET_EN
  input  logic [PC_W-1:0] p_count,
  output logic [31:0]     target,
`endif
  output dec_t            dec
);

  logic [5:0]  op;
  logic [15:0] imm;

  assign op  = instruction[31:26];
  assign imm = instruction[15:0];

  // Classify the opcode and fill only the fields its format defines.
  always_comb begin
    dec        = '0;
    dec.opcode = op;
    case (op)
      OP_RTYPE: begin
        dec.itype = IT_R;
        dec.rs    = instruction[25:21];
        dec.rt    = instruction[20:16];
        dec.rd    = instruction[15:11];
        dec.shamt = instruction[10:6];
        dec.funct = instruction[5:0];
      end
      OP_J, OP_JAL: begin
        dec.itype   = IT_J;
        dec.address = instruction[25:0];
      end
      default: begin
        dec.itype = IT_I;
        dec.rs    = instruction[25:21];
        dec.rt    = instruction[20:16];
        case (op)
          OP_ANDI, OP_ORI, OP_XORI: dec.imm_ext = {16'h0000, imm};
          OP_LUI:                   dec.imm_ext = {imm, 16'h0000};
          default:                  dec.imm_ext = {{16{imm[15]}}, imm};
        endcase
      end
    endcase
  end

`ifdef INST_DECODE_TARGET_EN
  logic [31:0] pc4;
  logic [31:0] br_off;

  assign pc4    = 32'(p_count) + 32'd4;
  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  // Next-PC candidate: jump region, branch offset, or fall-through.
  always_comb begin
    target = pc4;
    case (op)
      OP_J, OP_JAL:                     target = {pc4[31:28], instruction[25:0], 2'b00};
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: target = pc4 + br_off;
      default:                          target = pc4;
    endcase
  end
`endif

endmodule

// File: rtl/inst_decode_stage.sv
// Buffered MIPS-32 decode stage: decodes on push and holds records in a
// DEPTH-entry FIFO between fetch and register-read.
// Optional macro INST_DECODE_TARGET_EN adds the stored target field/port.
module inst_decode_stage
  import inst_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] p_count,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      itype,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [31:0]     imm_ext,
  output logic [25:0]     address,
`ifdef INST_DECODE_TARGET_EN
  output logic [31:0]     target,
`endif
  output logic [PC_W-1:0] pc_out
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dec_t            dec_in;
  dec_t            mem   [DEPTH];
  logic [PC_W-1:0] pcmem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;
  dec_t            head;

`ifdef INST_DECODE_TARGET_EN
  logic [31:0] tgt_in;
  logic [31:0] tgtmem [DEPTH];

  inst_field_decode #(.PC_W(PC_W)) u_dec (
    .instruction (instruction),
    .p_count     (p_count),
    .target      (tgt_in),
    .dec         (dec_in)
  );
`else
  inst_field_decode #(.PC_W(PC_W)) u_dec (
    .instruction (instruction),
    .dec         (dec_in)
  );
`endif

  assign in_ready  = (count < (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy bookkeeping; flush outranks push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Record storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr]   <= dec_in;
      pcmem[wr_ptr] <= p_count;
`ifdef INST_DECODE_TARGET_EN
      tgtmem[wr_ptr] <= tgt_in;
`endif
    end
  end

  // Head outputs read zero whenever the FIFO is empty.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign itype   = head.itype;
  assign opcode  = head.opcode;
  assign rs      = head.rs;
  assign rt      = head.rt;
  assign rd      = head.rd;
  assign shamt   = head.shamt;
  assign funct   = head.funct;
  assign imm_ext = head.imm_ext;
  assign address = head.address;
  assign pc_out  = out_valid ? pcmem[rd_ptr] : '0;
`ifdef INST_DECODE_TARGET_EN
  assign target  = out_valid ? tgtmem[rd_ptr] : '0;
`endif

endmodule
